// File: rtl/spr_pkg.sv
// Shared types and helpers for the symbol parameter RAM controller.
package spr_pkg;

  typedef enum logic [1:0] {
    HST_IDLE,
    HST_PEND,
    HST_ACC,
    HST_RESP
  } hst_state_e;

  typedef enum logic {
    OP_WR,
    OP_RD
  } hst_op_e;

  function automatic logic spr_rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Even parity: the stored bit makes the 9-bit lane have an even count of ones.
  function automatic logic spr_byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/spr_ram.sv
// Single-port byte-enable RAM, write-first, with RD_LAT output register stages.
// With SPR_PARITY_EN defined, one parity bit per byte lane is stored alongside the data.
module spr_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64,
  parameter int BE_W   = DATA_W / 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
`ifdef SPR_PARITY_EN
  input  logic [BE_W-1:0]   wpar,
  output logic [BE_W-1:0]   rpar,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q [RD_LAT];

  // Write-first: a write returns the merged word on its own read port.
  always_comb begin
    rd_d = mem[addr];
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) rd_d[i*8 +: 8] = wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rd_q[0] <= rd_d;
    end
    for (int s = 1; s < RD_LAT; s++) rd_q[s] <= rd_q[s-1];
  end

  assign rdata = rd_q[RD_LAT-1];

`ifdef SPR_PARITY_EN
  logic [BE_W-1:0] pmem [2**ADDR_W];
  logic [BE_W-1:0] par_d;
  logic [BE_W-1:0] par_q [RD_LAT];

  always_comb begin
    par_d = pmem[addr];
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) par_d[i] = wpar[i];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we && be[i]) pmem[addr][i] <= wpar[i];
      end
      par_q[0] <= par_d;
    end
    for (int s = 1; s < RD_LAT; s++) par_q[s] <= par_q[s-1];
  end

  assign rpar = par_q[RD_LAT-1];
`endif

endmodule

// File: rtl/symbol_param_ram_ctrl.sv
// Per-symbol parameter store: feed reads every cycle, host reads/writes slotted into idle cycles.
// Optional per-byte parity storage and checking is enabled by defining SPR_PARITY_EN.
module symbol_param_ram_ctrl
  import spr_pkg::*;
#(
  parameter int SPR_ADDR_W   = 14,
  parameter int SPR_DATA_W   = 64,
  parameter int SPR_BE_W     = SPR_DATA_W / 8,
  parameter int SPR_RD_LAT   = 2,
  parameter int SPR_HOST_ARB = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SPR_ADDR_W-1:0] t2t_rd_addr,
  input  logic                  sef_read,
  input  logic                  slf_inmsg,
  output logic [SPR_DATA_W-1:0] spr_rd_data,
  output logic                  spr_rd_valid,
  input  logic [SPR_ADDR_W-1:0] hpb_addr,
  input  logic [SPR_DATA_W-1:0] hpb_wr_data,
  input  logic [SPR_BE_W-1:0]   hpb_wr_be,
  input  logic                  hpb_wr_req,
  input  logic                  hpb_rd_req,
  output logic                  spr_wr_done,
  output logic [SPR_DATA_W-1:0] spr_hrd_data,
  output logic                  spr_rd_done,
  output logic                  spr_starve,
  input  logic                  spr_starve_clr
`ifdef SPR_PARITY_EN
  ,
  output logic                  spr_par_err
`endif
);

  // An illegal latency falls back to the default of 2 rather than building a broken pipe.
  localparam int RD_LAT = spr_rd_lat_ok(SPR_RD_LAT) ? SPR_RD_LAT : 2;
  localparam int CNT_W  = $clog2(SPR_HOST_ARB + 1);
  localparam logic [CNT_W-1:0] ARB_MAX  = CNT_W'(SPR_HOST_ARB);
  localparam logic             LAST_CNT = 1'(RD_LAT - 1);

  hst_state_e            state_q, state_d;
  hst_op_e               op_q, op_d;
  logic [SPR_ADDR_W-1:0] addr_q, addr_d;
  logic [SPR_DATA_W-1:0] wdata_q, wdata_d;
  logic [SPR_BE_W-1:0]   be_q, be_d;
  logic                  resp_cnt_q, resp_cnt_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d, starve_inc;
  logic                  starve_q, starve_d;
  logic [RD_LAT-1:0]     feed_vld_q, feed_vld_d;
  logic [RD_LAT-1:0]     hrd_vld_q, hrd_vld_d;
  logic [SPR_DATA_W-1:0] rd_hold_q, rd_hold_d;
  logic [SPR_DATA_W-1:0] hrd_q, hrd_d;

  logic                  host_ok, grant, host_done;
  logic                  ram_en, ram_we;
  logic [SPR_ADDR_W-1:0] ram_addr;
  logic [SPR_DATA_W-1:0] ram_rdata;

  // Writes wait out an in-flight message so a message never sees a half-updated word.
  assign host_ok   = (op_q == OP_WR) ? (!sef_read && !slf_inmsg) : !sef_read;
  assign grant     = (state_q == HST_PEND) && host_ok;
  assign host_done = (state_q == HST_RESP) && ((op_q == OP_WR) || (resp_cnt_q == LAST_CNT));

  assign ram_en   = sef_read || grant;
  assign ram_we   = grant && (op_q == OP_WR);
  assign ram_addr = sef_read ? t2t_rd_addr : addr_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    resp_cnt_d = resp_cnt_q;
    case (state_q)
      HST_IDLE: begin
        if (hpb_wr_req) begin
          state_d = HST_PEND;
          op_d    = OP_WR;
          addr_d  = hpb_addr;
          wdata_d = hpb_wr_data;
          be_d    = hpb_wr_be;
        end else if (hpb_rd_req) begin
          state_d = HST_PEND;
          op_d    = OP_RD;
          addr_d  = hpb_addr;
        end
      end
      HST_PEND: if (grant) state_d = HST_ACC;
      HST_ACC: begin
        state_d    = HST_RESP;
        resp_cnt_d = 1'b0;
      end
      HST_RESP: begin
        if (host_done) state_d = HST_IDLE;
        else           resp_cnt_d = resp_cnt_q + 1'b1;
      end
      default: state_d = HST_IDLE;
    endcase
  end

  always_comb begin
    starve_inc   = (starve_cnt_q == ARB_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
    starve_cnt_d = '0;
    starve_d     = starve_q;
    if (spr_starve_clr) starve_d = 1'b0;
    if ((state_q == HST_PEND) && !grant) begin
      starve_cnt_d = starve_inc;
      if (starve_inc == ARB_MAX) starve_d = 1'b1;
    end
  end

  always_comb begin
    feed_vld_d    = '0;
    hrd_vld_d     = '0;
    feed_vld_d[0] = sef_read;
    hrd_vld_d[0]  = grant && (op_q == OP_RD);
    for (int s = 1; s < RD_LAT; s++) begin
      feed_vld_d[s] = feed_vld_q[s-1];
      hrd_vld_d[s]  = hrd_vld_q[s-1];
    end
    rd_hold_d = spr_rd_data;
    hrd_d     = hrd_vld_q[RD_LAT-1] ? ram_rdata : hrd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HST_IDLE;
      op_q         <= OP_WR;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_cnt_q   <= 1'b0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
      feed_vld_q   <= '0;
      hrd_vld_q    <= '0;
      rd_hold_q    <= '0;
      hrd_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_cnt_q   <= resp_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
      feed_vld_q   <= feed_vld_d;
      hrd_vld_q    <= hrd_vld_d;
      rd_hold_q    <= rd_hold_d;
      hrd_q        <= hrd_d;
    end
  end

  assign spr_rd_valid = feed_vld_q[RD_LAT-1];
  assign spr_rd_data  = spr_rd_valid ? ram_rdata : rd_hold_q;
  assign spr_hrd_data = hrd_q;
  assign spr_wr_done  = host_done && (op_q == OP_WR);
  assign spr_rd_done  = host_done && (op_q == OP_RD);
  assign spr_starve   = starve_q;

`ifdef SPR_PARITY_EN
  logic [SPR_BE_W-1:0] ram_wpar, ram_rpar, calc_par;
  logic                par_bad;
  logic                hperr_q, hperr_d;

  always_comb begin
    ram_wpar = '0;
    calc_par = '0;
    for (int i = 0; i < SPR_BE_W; i++) begin
      ram_wpar[i] = spr_byte_parity(wdata_q[i*8 +: 8]);
      calc_par[i] = spr_byte_parity(ram_rdata[i*8 +: 8]);
    end
    par_bad = |(calc_par ^ ram_rpar);
    hperr_d = hrd_vld_q[RD_LAT-1] ? par_bad : hperr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hperr_q <= 1'b0;
    else          hperr_q <= hperr_d;
  end

  assign spr_par_err = (spr_rd_valid && par_bad) || (spr_rd_done && hperr_q);
`endif

  spr_ram #(
    .ADDR_W (SPR_ADDR_W),
    .DATA_W (SPR_DATA_W),
    .BE_W   (SPR_BE_W),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .be    (be_q),
`ifdef SPR_PARITY_EN
    .wpar  (ram_wpar),
    .rpar  (ram_rpar),
`endif
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_symbol_param_ram_ctrl.sv
// Directed, table-driven bench for symbol_param_ram_ctrl (default parameters, latency 2).
module tb_symbol_param_ram_ctrl;

  logic        clk;
  logic        reset_n;
  logic [13:0] t2t_rd_addr;
  logic        sef_read;
  logic        slf_inmsg;
  logic [63:0] spr_rd_data;
  logic        spr_rd_valid;
  logic [13:0] hpb_addr;
  logic [63:0] hpb_wr_data;
  logic [7:0]  hpb_wr_be;
  logic        hpb_wr_req;
  logic        hpb_rd_req;
  logic        spr_wr_done;
  logic [63:0] spr_hrd_data;
  logic        spr_rd_done;
  logic        spr_starve;
  logic        spr_starve_clr;
`ifdef SPR_PARITY_EN
  logic        spr_par_err;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [13:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  logic [13:0] seqAddr[3]  = '{14'h0000, 14'h0001, 14'h3FFF};
  logic [63:0] seqData[3]  = '{64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002, 64'h0BAD_C0DE_3FFF_3FFF};
  logic [13:0] feedAddr[5] = '{14'h0000, 14'h0001, 14'h3FFF, 14'h0010, 14'h0020};
  logic [63:0] feedData[5] = '{64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002, 64'h0BAD_C0DE_3FFF_3FFF,
                               64'hFFFF_FFFF_5566_7788, 64'hA523_4567_89AB_CDA5};

  symbol_param_ram_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .t2t_rd_addr    (t2t_rd_addr),
    .sef_read       (sef_read),
    .slf_inmsg      (slf_inmsg),
    .spr_rd_data    (spr_rd_data),
    .spr_rd_valid   (spr_rd_valid),
    .hpb_addr       (hpb_addr),
    .hpb_wr_data    (hpb_wr_data),
    .hpb_wr_be      (hpb_wr_be),
    .hpb_wr_req     (hpb_wr_req),
    .hpb_rd_req     (hpb_rd_req),
    .spr_wr_done    (spr_wr_done),
    .spr_hrd_data   (spr_hrd_data),
    .spr_rd_done    (spr_rd_done),
    .spr_starve     (spr_starve),
    .spr_starve_clr (spr_starve_clr)
`ifdef SPR_PARITY_EN
    ,
    .spr_par_err    (spr_par_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hostWrite(input logic [13:0] a, input logic [63:0] d, input logic [7:0] be,
                           input int expLat, input string name);
    int   cyc  = 0;
    logic seen = 1'b0;
    @(posedge clk); #1;
    hpb_addr    = a;
    hpb_wr_data = d;
    hpb_wr_be   = be;
    hpb_wr_req  = 1'b1;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (spr_wr_done) seen = 1'b1;
    end
    hpb_wr_req = 1'b0;
    checkOutput({name, " wr_done"}, 64'(seen), 64'd1);
    if (expLat > 0) checkOutput({name, " wr latency"}, 64'(cyc), 64'(expLat));
  endtask

  task automatic hostRead(input logic [13:0] a, input logic [63:0] exp, input int expLat,
                          input string name);
    int   cyc  = 0;
    logic seen = 1'b0;
    @(posedge clk); #1;
    hpb_addr   = a;
    hpb_rd_req = 1'b1;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (spr_rd_done) seen = 1'b1;
    end
    hpb_rd_req = 1'b0;
    checkOutput({name, " rd_done"}, 64'(seen), 64'd1);
    checkOutput({name, " hrd_data"}, spr_hrd_data, exp);
    if (expLat > 0) checkOutput({name, " rd latency"}, 64'(cyc), 64'(expLat));
  endtask

  task automatic feedRead(input logic [13:0] a, input logic [63:0] exp, input string name);
    @(posedge clk); #1;
    sef_read    = 1'b1;
    t2t_rd_addr = a;
    @(posedge clk); #1;
    sef_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, " feed valid"}, 64'(spr_rd_valid), 64'd1);
    checkOutput({name, " feed data"}, spr_rd_data, exp);
  endtask

  task automatic applyStimulus(input int idx);
    hostWrite(vecs[idx].addr, vecs[idx].data, vecs[idx].be, 4, $sformatf("vec%0d", idx));
    hostRead(vecs[idx].addr, vecs[idx].exp, 5, $sformatf("vec%0d", idx));
  endtask

  initial begin
    vecs[0] = '{14'h0000, 64'hDEAD_BEEF_0000_0001, 8'hFF, 64'hDEAD_BEEF_0000_0001};
    vecs[1] = '{14'h0001, 64'hCAFE_F00D_0000_0002, 8'hFF, 64'hCAFE_F00D_0000_0002};
    vecs[2] = '{14'h3FFF, 64'h0BAD_C0DE_3FFF_3FFF, 8'hFF, 64'h0BAD_C0DE_3FFF_3FFF};
    vecs[3] = '{14'h0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{14'h0010, 64'h1122_3344_5566_7788, 8'h0F, 64'hFFFF_FFFF_5566_7788};
    vecs[5] = '{14'h0010, 64'h0000_0000_0000_0000, 8'h00, 64'hFFFF_FFFF_5566_7788};
    vecs[6] = '{14'h0020, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF};
    vecs[7] = '{14'h0020, 64'hA5A5_A5A5_A5A5_A5A5, 8'h81, 64'hA523_4567_89AB_CDA5};

    reset_n        = 1'b0;
    t2t_rd_addr    = '0;
    sef_read       = 1'b0;
    slf_inmsg      = 1'b0;
    hpb_addr       = '0;
    hpb_wr_data    = '0;
    hpb_wr_be      = '0;
    hpb_wr_req     = 1'b0;
    hpb_rd_req     = 1'b0;
    spr_starve_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset rd_valid", 64'(spr_rd_valid), 64'd0);
    checkOutput("reset rd_data", spr_rd_data, 64'd0);
    checkOutput("reset hrd_data", spr_hrd_data, 64'd0);
    checkOutput("reset done flags", 64'({spr_wr_done, spr_rd_done, spr_starve}), 64'd0);
    reset_n = 1'b1;

    for (int v = 0; v < 8; v++) applyStimulus(v);

    // Three back-to-back feed reads arrive two cycles later, in order, then data holds.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        sef_read    = 1'b1;
        t2t_rd_addr = seqAddr[k];
      end else begin
        sef_read = 1'b0;
      end
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        checkOutput($sformatf("seq beat%0d valid", k - 2), 64'(spr_rd_valid), 64'd1);
        checkOutput($sformatf("seq beat%0d data", k - 2), spr_rd_data, seqData[k-2]);
      end else begin
        checkOutput($sformatf("seq cycle%0d valid low", k), 64'(spr_rd_valid), 64'd0);
      end
      if (k == 5) checkOutput("seq data hold", spr_rd_data, seqData[2]);
    end

    // Write deferred by an in-flight message; feed still sees the old word.
    begin
      logic seen;
      int   cyc;
      hostWrite(14'h0040, 64'h4040_4040_0000_0000, 8'hFF, 4, "inmsg old");
      @(posedge clk); #1;
      slf_inmsg   = 1'b1;
      hpb_addr    = 14'h0040;
      hpb_wr_data = 64'h0000_0000_4040_4040;
      hpb_wr_be   = 8'hFF;
      hpb_wr_req  = 1'b1;
      seen = 1'b0;
      repeat (17) begin
        @(negedge clk);
        if (spr_wr_done) seen = 1'b1;
      end
      feedRead(14'h0040, 64'h4040_4040_0000_0000, "inmsg during");
      if (spr_wr_done) seen = 1'b1;
      checkOutput("inmsg no wr_done", 64'(seen), 64'd0);
      @(posedge clk); #1;
      slf_inmsg = 1'b0;
      cyc = 0;
      while (!seen && cyc < 4) begin
        @(negedge clk);
        cyc++;
        if (spr_wr_done) seen = 1'b1;
      end
      hpb_wr_req = 1'b0;
      checkOutput("inmsg wr_done after release", 64'(seen), 64'd1);
      feedRead(14'h0040, 64'h0000_0000_4040_4040, "inmsg after");
    end

    // Feed read of the written address in the cycle right after ACC sees new data.
    @(posedge clk); #1;
    hpb_addr    = 14'h0080;
    hpb_wr_data = 64'h8080_1234_5678_8080;
    hpb_wr_be   = 8'hFF;
    hpb_wr_req  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    sef_read    = 1'b1;
    t2t_rd_addr = 14'h0080;
    @(negedge clk);
    checkOutput("raw wr_done", 64'(spr_wr_done), 64'd1);
    hpb_wr_req = 1'b0;
    @(posedge clk); #1;
    sef_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("raw feed valid", 64'(spr_rd_valid), 64'd1);
    checkOutput("raw feed data", spr_rd_data, 64'h8080_1234_5678_8080);

    // Continuous feed starves a pending host write; feed data must stay correct.
    begin
      logic seen;
      int   cyc;
      hpb_addr    = 14'h0050;
      hpb_wr_data = 64'h5050_5050_ABCD_EF01;
      hpb_wr_be   = 8'hFF;
      hpb_wr_req  = 1'b1;
      for (int i = 0; i < 110; i++) begin
        @(posedge clk); #1;
        sef_read    = 1'b1;
        t2t_rd_addr = feedAddr[i % 5];
        @(negedge clk);
        if (i >= 2) checkOutput($sformatf("starve feed%0d", i), spr_rd_data, feedData[(i-2) % 5]);
        if (i == 60) checkOutput("starve feed valid", 64'(spr_rd_valid), 64'd1);
        if (i == 60) checkOutput("starve no early done", 64'(spr_wr_done), 64'd0);
        if (i == 97) checkOutput("starve not yet", 64'(spr_starve), 64'd0);
        if (i == 104) checkOutput("starve set", 64'(spr_starve), 64'd1);
      end
      @(posedge clk); #1;
      sef_read = 1'b0;
      seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < 10) begin
        @(negedge clk);
        cyc++;
        if (spr_wr_done) seen = 1'b1;
      end
      hpb_wr_req = 1'b0;
      checkOutput("starve wr_done", 64'(seen), 64'd1);
      checkOutput("starve sticky", 64'(spr_starve), 64'd1);
      @(posedge clk); #1;
      spr_starve_clr = 1'b1;
      @(posedge clk); #1;
      spr_starve_clr = 1'b0;
      @(negedge clk);
      checkOutput("starve cleared", 64'(spr_starve), 64'd0);
      hostRead(14'h0050, 64'h5050_5050_ABCD_EF01, 5, "starve readback");
      checkOutput("starve stays clear", 64'(spr_starve), 64'd0);
    end

    // Simultaneous requests: write first, then the read returns the written data.
    begin
      logic wrSeen;
      logic rdEarly;
      int   cyc;
      @(posedge clk); #1;
      hpb_addr    = 14'h0060;
      hpb_wr_data = 64'h6060_0BB0_C11C_6060;
      hpb_wr_be   = 8'hFF;
      hpb_wr_req  = 1'b1;
      hpb_rd_req  = 1'b1;
      wrSeen = 1'b0;
      rdEarly = 1'b0;
      cyc = 0;
      while (!wrSeen && cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (spr_rd_done) rdEarly = 1'b1;
        if (spr_wr_done) wrSeen = 1'b1;
      end
      hpb_wr_req = 1'b0;
      checkOutput("both wr_done", 64'(wrSeen), 64'd1);
      checkOutput("both read not first", 64'(rdEarly), 64'd0);
      cyc = 0;
      while (!spr_rd_done && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput("both rd_done", 64'(spr_rd_done), 64'd1);
      checkOutput("both rd data", spr_hrd_data, 64'h6060_0BB0_C11C_6060);
      hpb_rd_req = 1'b0;
    end

    // Reset during ACC of a write aborts it without a done pulse.
    begin
      logic seen;
      @(posedge clk); #1;
      hpb_addr    = 14'h0070;
      hpb_wr_data = 64'h7070_7070_7070_7070;
      hpb_wr_be   = 8'hFF;
      hpb_wr_req  = 1'b1;
      @(posedge clk);
      @(posedge clk); #3;
      reset_n    = 1'b0;
      hpb_wr_req = 1'b0;
      #1;
      checkOutput("abort rd_valid", 64'(spr_rd_valid), 64'd0);
      checkOutput("abort rd_data", spr_rd_data, 64'd0);
      checkOutput("abort hrd_data", spr_hrd_data, 64'd0);
      checkOutput("abort done flags", 64'({spr_wr_done, spr_rd_done, spr_starve}), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (spr_wr_done) seen = 1'b1;
      end
      checkOutput("abort no wr_done", 64'(seen), 64'd0);
      hostWrite(14'h0070, 64'h0707_0707_1234_0707, 8'hFF, 4, "post reset");
      hostRead(14'h0070, 64'h0707_0707_1234_0707, 5, "post reset");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
